// File: rtl/debug_if.sv
// Host/pipeline-facing signal bundle of the debug unit: UART byte handshakes plus pipeline debug taps.
interface debug_if #(
    parameter int BUS_W   = 144,
    parameter int INSTR_W = 32
);
    logic               rx_done_tick;
    logic [7:0]         rx_bus;
    logic               tx_done_tick;
    logic               tx_start;
    logic [7:0]         tx_bus;
    logic [BUS_W-1:0]   bus_UART;
    logic [INSTR_W-1:0] instruccion;
    logic               clockPipeline;
    logic               resetUART;

    modport master (
        output rx_done_tick, rx_bus, tx_done_tick, bus_UART, instruccion,
        input  tx_start, tx_bus, clockPipeline, resetUART
    );

    modport slave (
        input  rx_done_tick, rx_bus, tx_done_tick, bus_UART, instruccion,
        output tx_start, tx_bus, clockPipeline, resetUART
    );
endinterface

// File: rtl/debug_unit.sv
// Single-byte command decoder that single-steps / resets the pipeline and streams
// a {step_cnt, bus_UART, instruccion} snapshot back to the host one byte per tx handshake.
module debug_unit #(
    parameter int         BUS_W      = 144,
    parameter int         INSTR_W    = 32,
    parameter int         STEP_HIGH  = 4,
    parameter int         RST_CYCLES = 16,
    parameter logic [7:0] CMD_STEP   = 8'h53,
    parameter logic [7:0] CMD_DUMP   = 8'h44,
    parameter logic [7:0] CMD_RST    = 8'h52
) (
    input  logic     clk,
    input  logic     reset,
    debug_if.slave   dbg
);
    localparam int N       = 1 + BUS_W/8 + INSTR_W/8;
    localparam int FRAME_W = 8*N;
    localparam int IDX_W   = $clog2(N);
    localparam int CNT_MAX = (STEP_HIGH > RST_CYCLES) ? STEP_HIGH : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, STEP_HI, STEP_LO, LATCH, SEND, WAIT_DONE, RST
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         step_cnt_q, step_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] snap_q, snap_d;
    logic [FRAME_W-1:0] frame_sh;
    logic               done_q, done_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_bus_q, tx_bus_d;
    logic               clk_pipe_q, clk_pipe_d;
    logic               rst_pipe_q, rst_pipe_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (dbg.rx_done_tick) begin
                if      (dbg.rx_bus == CMD_STEP) state_d = STEP_HI;
                else if (dbg.rx_bus == CMD_DUMP) state_d = LATCH;
                else if (dbg.rx_bus == CMD_RST)  state_d = RST;
            end
            STEP_HI:   if (cnt_q == CNT_W'(STEP_HIGH - 1)) state_d = STEP_LO;
            STEP_LO:   if (cnt_q == CNT_W'(STEP_HIGH - 1)) state_d = LATCH;
            LATCH:     state_d = SEND;
            SEND:      state_d = WAIT_DONE;
            WAIT_DONE: if (done_q) state_d = (idx_q == IDX_W'(N - 1)) ? IDLE : SEND;
            RST:       if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        cnt_d      = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        step_cnt_d = step_cnt_q;
        if (state_q == IDLE && state_d == RST)
            step_cnt_d = '0;
        else if (state_q == STEP_HI && state_d == STEP_LO)
            step_cnt_d = step_cnt_q + 8'd1;
        snap_d = (state_q == LATCH) ? {step_cnt_q, dbg.bus_UART, dbg.instruccion} : snap_q;
        idx_d  = idx_q;
        if (state_q == LATCH)
            idx_d = '0;
        else if (state_q == WAIT_DONE && state_d == SEND)
            idx_d = idx_q + 1'b1;
        frame_sh   = snap_d << {idx_d, 3'b000};
        tx_start_d = (state_d == SEND);
        tx_bus_d   = (state_d == SEND) ? frame_sh[FRAME_W-1 -: 8] : tx_bus_q;
        clk_pipe_d = (state_d == STEP_HI);
        rst_pipe_d = (state_d == RST);
        // Registering the done strobe spaces consecutive bytes two cycles after tx_done_tick.
        done_d     = dbg.tx_done_tick && (state_q == WAIT_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            step_cnt_q <= '0;
            idx_q      <= '0;
            snap_q     <= '0;
            done_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_bus_q   <= '0;
            clk_pipe_q <= 1'b0;
            rst_pipe_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            step_cnt_q <= step_cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            tx_bus_q   <= tx_bus_d;
            clk_pipe_q <= clk_pipe_d;
            rst_pipe_q <= rst_pipe_d;
        end
    end

    assign dbg.tx_start      = tx_start_q;
    assign dbg.tx_bus        = tx_bus_q;
    assign dbg.clockPipeline = clk_pipe_q;
    assign dbg.resetUART     = rst_pipe_q;

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: auto-responding tx_done, byte monitor, and a frame model built from the frame rules.
module tb_debug_unit;
    localparam int BUS_W = 144, INSTR_W = 32, N = 1 + BUS_W/8 + INSTR_W/8;

    logic clk, reset;
    debug_if #(.BUS_W(BUS_W), .INSTR_W(INSTR_W)) dif();

    debug_unit #(.BUS_W(BUS_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .reset(reset), .dbg(dif)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    int cmd_cyc;
    int resp_dly = 10;
    int cp_hi, ru_hi;
    logic scramble = 1'b0;
    logic [7:0] got[$];
    int st_cyc[$];
    int done_cyc[$];
    int pend[$];
    logic [7:0] expq[$];
    int step_m = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every tx_start byte and high cycles of the pipeline controls.
    initial forever begin
        @(negedge clk);
        if (dif.tx_start === 1'b1) begin
            got.push_back(dif.tx_bus);
            st_cyc.push_back(cyc);
        end
        if (dif.clockPipeline === 1'b1) cp_hi++;
        if (dif.resetUART === 1'b1) ru_hi++;
    end

    // uart_tx stand-in: tx_done_tick resp_dly cycles after each tx_start.
    initial begin
        dif.tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            dif.tx_done_tick = 1'b0;
            if (dif.tx_start === 1'b1) pend.push_back(cyc + resp_dly);
            if (pend.size() > 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                dif.tx_done_tick = 1'b1;
                done_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, cycle=%0d required=<90000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clr();
        got.delete(); st_cyc.delete(); done_cyc.delete();
        cp_hi = 0; ru_hi = 0;
    endtask

    task automatic rand_inputs();
        logic [BUS_W-1:0] b;
        for (int i = 0; i < BUS_W/8; i++) b[i*8 +: 8] = 8'($urandom);
        dif.bus_UART    = b;
        dif.instruccion = $urandom;
    endtask

    // Frame model: step count, then bus bytes MS first, then instruction bytes MS first.
    task automatic mk_exp(input int sc, input logic [BUS_W-1:0] b, input logic [INSTR_W-1:0] ins);
        expq.delete();
        expq.push_back(8'(sc));
        for (int i = BUS_W/8 - 1; i >= 0; i--) expq.push_back(b[i*8 +: 8]);
        for (int i = INSTR_W/8 - 1; i >= 0; i--) expq.push_back(ins[i*8 +: 8]);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk);
        dif.rx_bus = c;
        dif.rx_done_tick = 1'b1;
        cmd_cyc = cyc;
        @(negedge clk);
        dif.rx_done_tick = 1'b0;
        dif.rx_bus = 8'($urandom);
    endtask

    task automatic wait_frame(input int n);
        int t = 0;
        while (got.size() < n && t < n*(resp_dly + 4) + 40) begin
            @(negedge clk);
            t++;
            if (scramble && got.size() > 0) rand_inputs();
        end
        checks++;
        if (got.size() < n) begin
            failures++;
            $display("FAIL frame_timeout: bytes=%0d required=%0d", got.size(), n);
        end
        repeat (resp_dly + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dif.rx_done_tick = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rand_inputs();
            dif.rx_bus = 8'($urandom);
            checks++;
            if ({dif.tx_start, dif.tx_bus, dif.clockPipeline, dif.resetUART} !== 11'd0) begin
                failures++;
                $display("FAIL reset_outputs: got=%b required=0",
                         {dif.tx_start, dif.tx_bus, dif.clockPipeline, dif.resetUART});
            end
        end
        @(negedge clk);
        reset = 1'b1;
        clr();
        repeat (8) @(negedge clk);
        checks++;
        if (got.size() != 0 || cp_hi != 0 || ru_hi != 0) begin
            failures++;
            $display("FAIL reset_idle: bytes=%0d cp=%0d ru=%0d required=0", got.size(), cp_hi, ru_hi);
        end
    endtask

    task automatic test_dump();
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                dif.bus_UART    = 144'h010203040506070809_0a0b0c0d0e0f101112;
                dif.instruccion = 32'hDEADBEEF;
            end else rand_inputs();
            mk_exp(step_m, dif.bus_UART, dif.instruccion);
            clr();
            scramble = 1'b1;
            send_cmd(CMD_D());
            wait_frame(N);
            scramble = 1'b0;
            checks++;
            if (got.size() != N) begin
                failures++;
                $display("FAIL dump_len: got=%0d required=%0d", got.size(), N);
            end
            for (int i = 0; i < got.size() && i < N; i++) begin
                checks++;
                if (got[i] !== expq[i]) begin
                    failures++;
                    $display("FAIL dump_byte[%0d]: got=%h required=%h", i, got[i], expq[i]);
                end
            end
            checks++;
            if (st_cyc.size() == 0 || st_cyc[0] - cmd_cyc != 2) begin
                failures++;
                $display("FAIL dump_latency: got=%0d required=2",
                         st_cyc.size() ? st_cyc[0] - cmd_cyc : -1);
            end
            for (int k = 1; k < st_cyc.size() && k <= done_cyc.size(); k++) begin
                checks++;
                if (st_cyc[k] - done_cyc[k-1] != 2) begin
                    failures++;
                    $display("FAIL back_to_back[%0d]: gap=%0d required=2", k, st_cyc[k] - done_cyc[k-1]);
                end
            end
        end
    endtask

    function automatic logic [7:0] CMD_D(); return 8'h44; endfunction

    task automatic test_step();
        for (int r = 0; r < 3; r++) begin
            rand_inputs();
            step_m = (step_m + 1) % 256;
            mk_exp(step_m, dif.bus_UART, dif.instruccion);
            clr();
            send_cmd(8'h53);
            wait_frame(N);
            checks++;
            if (cp_hi != 4) begin
                failures++;
                $display("FAIL step_clock_high: got=%0d required=4", cp_hi);
            end
            checks++;
            if (st_cyc.size() == 0 || st_cyc[0] - cmd_cyc != 10) begin
                failures++;
                $display("FAIL step_latency: got=%0d required=10",
                         st_cyc.size() ? st_cyc[0] - cmd_cyc : -1);
            end
            for (int i = 0; i < got.size() && i < N; i++) begin
                checks++;
                if (got[i] !== expq[i]) begin
                    failures++;
                    $display("FAIL step_byte[%0d]: got=%h required=%h", i, got[i], expq[i]);
                end
            end
        end
        clr();
        send_cmd(8'h52);
        step_m = 0;
        repeat (30) @(negedge clk);
        checks++;
        if (ru_hi != 16 || got.size() != 0) begin
            failures++;
            $display("FAIL rst_cmd: resetUART_cycles=%0d bytes=%0d required=16,0", ru_hi, got.size());
        end
        rand_inputs();
        mk_exp(step_m, dif.bus_UART, dif.instruccion);
        clr();
        send_cmd(8'h44);
        wait_frame(N);
        for (int i = 0; i < got.size() && i < N; i++) begin
            checks++;
            if (got[i] !== expq[i]) begin
                failures++;
                $display("FAIL post_rst_byte[%0d]: got=%h required=%h", i, got[i], expq[i]);
            end
        end
    endtask

    task automatic test_ignore();
        int t = 0;
        clr();
        send_cmd(8'h41);
        repeat (10) @(negedge clk);
        checks++;
        if (got.size() != 0 || cp_hi != 0 || ru_hi != 0) begin
            failures++;
            $display("FAIL unknown_cmd: bytes=%0d cp=%0d ru=%0d required=0", got.size(), cp_hi, ru_hi);
        end
        rand_inputs();
        mk_exp(step_m, dif.bus_UART, dif.instruccion);
        clr();
        send_cmd(8'h44);
        while (got.size() < 3 && t < 100) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        send_cmd(8'h53);
        wait_frame(N);
        repeat (20) @(negedge clk);
        checks++;
        if (got.size() != N || cp_hi != 0) begin
            failures++;
            $display("FAIL busy_drop: bytes=%0d cp=%0d required=%0d,0", got.size(), cp_hi, N);
        end
        for (int i = 0; i < got.size() && i < N; i++) begin
            checks++;
            if (got[i] !== expq[i]) begin
                failures++;
                $display("FAIL busy_byte[%0d]: got=%h required=%h", i, got[i], expq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        clr();
        send_cmd(8'h53);
        while (dif.clockPipeline !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({dif.tx_start, dif.tx_bus, dif.clockPipeline, dif.resetUART} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_step: got=%b required=0",
                     {dif.tx_start, dif.tx_bus, dif.clockPipeline, dif.resetUART});
        end
        @(negedge clk);
        reset = 1'b1;
        step_m = 0;
        clr();
        send_cmd(8'h44);
        t = 0;
        while (got.size() < 6 && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        pend.delete();
        checks++;
        if (got.size() != 6 || {dif.tx_start, dif.tx_bus, dif.clockPipeline, dif.resetUART} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_frame: bytes=%0d outs=%b required=6,0", got.size(),
                     {dif.tx_start, dif.tx_bus, dif.clockPipeline, dif.resetUART});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (got.size() != 6) begin
            failures++;
            $display("FAIL frame_abandoned: bytes=%0d required=6", got.size());
        end
        rand_inputs();
        mk_exp(step_m, dif.bus_UART, dif.instruccion);
        clr();
        send_cmd(8'h44);
        wait_frame(N);
        checks++;
        if (got.size() != N) begin
            failures++;
            $display("FAIL post_reset_len: got=%0d required=%0d", got.size(), N);
        end
        for (int i = 0; i < got.size() && i < N; i++) begin
            checks++;
            if (got[i] !== expq[i]) begin
                failures++;
                $display("FAIL post_reset_byte[%0d]: got=%h required=%h", i, got[i], expq[i]);
            end
        end
    endtask

    task automatic test_wrap();
        resp_dly = 1;
        send_cmd(8'h52);
        step_m = 0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 256; k++) begin
            rand_inputs();
            clr();
            step_m = (step_m + 1) % 256;
            send_cmd(8'h53);
            wait_frame(N);
            checks++;
            if (got.size() == 0 || got[0] !== 8'(step_m)) begin
                failures++;
                $display("FAIL wrap_first_byte[%0d]: got=%h required=%h", k,
                         got.size() ? got[0] : 8'hxx, 8'(step_m));
            end
        end
        checks++;
        if (got.size() == 0 || got[0] !== 8'h00) begin
            failures++;
            $display("FAIL wrap_final: got=%h required=00", got.size() ? got[0] : 8'hxx);
        end
        resp_dly = 10;
    endtask

    initial begin
        dif.rx_done_tick = 1'b0;
        dif.rx_bus = '0;
        dif.bus_UART = '0;
        dif.instruccion = '0;
        test_reset();
        test_dump();
        test_step();
        test_ignore();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Command/response controller between the UART byte layer (uart_rx/uart_tx) and the pipeline under debug.
- Decodes single-byte host commands and single-steps the pipeline by driving clockPipeline.
- Controls pipeline reset and streams a snapshot of the pipeline debug bus plus the current instruction back to the host, byte by byte, over the tx handshake.

Parameters:
- BUS_W, 144, width of bus_UART; must be a multiple of 8.
- INSTR_W, 32, width of instruccion; must be a multiple of 8.
- STEP_HIGH, 4, cycles clockPipeline is held high per step; the same number of low settle cycles follows.
- RST_CYCLES, 16, cycles resetUART is held high per reset command.
- CMD_STEP, 8'h53 ('S'), step the pipeline once, then dump.
- CMD_DUMP, 8'h44 ('D'), dump without stepping.
- CMD_RST, 8'h52 ('R'), reset the pipeline and clear the step counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_done_tick  in  1  one-cycle strobe; rx_bus holds a valid byte.
- rx_bus  in  8  received byte.
- tx_done_tick  in  1  one-cycle strobe; uart_tx has finished the current byte.
- tx_start  out  1  one-cycle request to send tx_bus.
- tx_bus  out  8  byte to transmit.
- bus_UART  in  BUS_W  pipeline debug bus.
- instruccion  in  INSTR_W  instruction currently in fetch.
- clockPipeline  out  1  pipeline clock pulse.
- resetUART  out  1  active-high pipeline reset.

Behaviour:
- Reset values (reset low, asynchronous):
  - state=IDLE; tx_start=0; tx_bus=0; clockPipeline=0; resetUART=0.
  - step_cnt=0; byte index=0; snapshot=0.
- All outputs are registered.
- States: IDLE, STEP_HI, STEP_LO, LATCH, SEND, WAIT_DONE, RST.
- IDLE: rx_done_tick is sampled only in IDLE. Transitions on rx_done_tick by rx_bus value:
  - CMD_STEP -> STEP_HI.
  - CMD_DUMP -> LATCH.
  - CMD_RST -> RST.
  - Any other byte is ignored; state stays IDLE.
- rx_done_tick in any other state is dropped. No queueing.
- STEP_HI: clockPipeline=1 for exactly STEP_HIGH cycles -> STEP_LO.
- STEP_LO: clockPipeline=0 for STEP_HIGH cycles -> LATCH. step_cnt increments (8-bit, wraps 255->0) on the STEP_HI->STEP_LO transition.
- LATCH: captures {step_cnt, bus_UART, instruccion} into the snapshot in one cycle. Byte index=0 -> SEND.
- Frame format:
  - N = 1 + BUS_W/8 + INSTR_W/8 = 23 bytes at defaults.
  - Byte order: step_cnt first, then bus_UART from its MS byte ([143:136]) down to its LS byte, then instruccion from its MS byte down to its LS byte.
  - The snapshot does not change while the frame is being sent; input changes during sending are not reflected.
- SEND: tx_bus=snapshot byte[index]; tx_start=1 for exactly one cycle -> WAIT_DONE.
- WAIT_DONE: tx_bus is held stable.
  - On tx_done_tick: if index=N-1 -> IDLE, else index+1 -> SEND.
  - tx_done_tick outside WAIT_DONE is ignored.
- RST: resetUART=1 for exactly RST_CYCLES cycles, then 0 -> IDLE. step_cnt is cleared to 0 on entry. No frame is sent.
- Latency:
  - rx_done_tick with CMD_DUMP sampled at edge t -> LATCH in cycle t+1 -> tx_start high in cycle t+2.
  - CMD_STEP: first tx_start occurs 2*STEP_HIGH+2 cycles after the command edge.
- Back-to-back: the next byte is sent two cycles after tx_done_tick at the earliest.
- Reset mid-operation: asynchronous return to the reset values. In particular clockPipeline and resetUART drop immediately, and a partial frame is abandoned.
- No timeout. A missing tx_done_tick stalls in WAIT_DONE until reset.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0; after release, the FSM is in IDLE with no tx_start.
- 'D' with bus_UART=144'h0102...12, instruccion=32'hDEADBEEF, tx_done_tick returned 10 cycles after each tx_start:
  - 23 tx_start pulses, tx_bus sequence 00,01..12,DE,AD,BE,EF.
  - First tx_start 2 cycles after rx_done_tick.
- 'S' three times, each frame completed:
  - clockPipeline high exactly 4 cycles per command.
  - First byte of the frames = 01, 02, 03.
  - Then 'R': resetUART high exactly 16 cycles, no tx_start; the next 'D' frame's first byte = 00.
- Unknown byte 8'h41, and a 'S' sent while a frame is in WAIT_DONE -> no state change, no extra clockPipeline pulse; the frame completes normally.
- Assert reset while clockPipeline=1 and during frame byte 5 -> outputs 0 immediately; the next 'D' returns a full 23-byte frame.
- Step counter wrap: 256 'S' commands -> first byte of the last frame = 00.
